// File: rtl/chunked_borrow_subtractor.sv
// rtl/chunked_borrow_subtractor.sv - multi-cycle A - B - Bin, CHUNK bits per clock
// Operands shift right one chunk per cycle; the difference shifts in from the top.
module chunked_borrow_subtractor #(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic         CLK_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] A_i,
  input  logic [W-1:0] B_i,
  input  logic         Bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] D_o,
  output logic         Bout_o,
  output logic [W:0]   full_diff
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((W % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_borrow_subtractor: W must be a multiple of CHUNK");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, res_q;
  logic [W-1:0]    a_next, b_next, res_next;
  logic            borrow_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    d_q;
  logic            bout_q;
  logic            done_q;

  logic [CHUNK-1:0] a_c, b_c, g_c, p_c, diff_c;
  logic [CHUNK:0]   bc;
  logic             last_chunk;

  // Borrow lookahead across the current (lowest) chunk of the working operands.
  always_comb begin
    a_c    = a_q[CHUNK-1:0];
    b_c    = b_q[CHUNK-1:0];
    g_c    = ~a_c & b_c;
    p_c    = ~(a_c ^ b_c);
    bc     = '0;
    diff_c = '0;
    bc[0]  = borrow_q;
    for (int j = 0; j < CHUNK; j++) begin
      bc[j+1]   = g_c[j] | (p_c[j] & bc[j]);
      diff_c[j] = a_c[j] ^ b_c[j] ^ bc[j];
    end
  end

  if (CHUNK == W) begin : g_single
    assign a_next   = '0;
    assign b_next   = '0;
    assign res_next = diff_c;
  end else begin : g_multi
    assign a_next   = {{CHUNK{1'b0}}, a_q[W-1:CHUNK]};
    assign b_next   = {{CHUNK{1'b0}}, b_q[W-1:CHUNK]};
    assign res_next = {diff_c, res_q[W-1:CHUNK]};
  end

  assign last_chunk = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i) begin
          a_q      <= A_i;
          b_q      <= B_i;
          borrow_q <= Bin_i;
          res_q    <= '0;
          cnt_q    <= '0;
        end
      end else begin
        a_q      <= a_next;
        b_q      <= b_next;
        res_q    <= res_next;
        borrow_q <= bc[CHUNK];
        cnt_q    <= cnt_q + 1'b1;
        // Outputs only move on the completion edge so they hold through BUSY.
        if (last_chunk) begin
          d_q    <= res_next;
          bout_q <= bc[CHUNK];
          done_q <= 1'b1;
          cnt_q  <= '0;
        end
      end
    end
  end

  assign busy_o    = (state_q == BUSY);
  assign done_o    = done_q;
  assign D_o       = d_q;
  assign Bout_o    = bout_q;
  assign full_diff = {bout_q, d_q};

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// tb/tb_chunked_borrow_subtractor.sv - scoreboard bench for chunked_borrow_subtractor
// Three instances: CHUNK=4 (index 0), CHUNK=16 (index 1), CHUNK=1 (index 2).
module tb_chunked_borrow_subtractor;

  localparam int W = 16;

  typedef struct {
    logic [W:0] fd;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic         rst   [3];
  logic         start [3];
  logic [W-1:0] a     [3];
  logic [W-1:0] b     [3];
  logic         bin   [3];
  logic         busy  [3];
  logic         done  [3];
  logic [W-1:0] d     [3];
  logic         bout  [3];
  logic [W:0]   fd    [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  chunked_borrow_subtractor #(.W(W), .CHUNK(4)) u_c4 (
    .CLK_i(clk), .rst_i(rst[0]), .start_i(start[0]), .A_i(a[0]), .B_i(b[0]),
    .Bin_i(bin[0]), .busy_o(busy[0]), .done_o(done[0]), .D_o(d[0]),
    .Bout_o(bout[0]), .full_diff(fd[0])
  );

  chunked_borrow_subtractor #(.W(W), .CHUNK(16)) u_c16 (
    .CLK_i(clk), .rst_i(rst[1]), .start_i(start[1]), .A_i(a[1]), .B_i(b[1]),
    .Bin_i(bin[1]), .busy_o(busy[1]), .done_o(done[1]), .D_o(d[1]),
    .Bout_o(bout[1]), .full_diff(fd[1])
  );

  chunked_borrow_subtractor #(.W(W), .CHUNK(1)) u_c1 (
    .CLK_i(clk), .rst_i(rst[2]), .start_i(start[2]), .A_i(a[2]), .B_i(b[2]),
    .Bin_i(bin[2]), .busy_o(busy[2]), .done_o(done[2]), .D_o(d[2]),
    .Bout_o(bout[2]), .full_diff(fd[2])
  );

  function automatic int nc(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, wrapped to W+1 bits.
  task automatic push_exp(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi);
    exp_t e;
    int   r;
    r     = int'(av) - int'(bv) - int'(bi);
    e.fd  = (W+1)'(r);
    e.acc = cyc + 1;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    ok    = 1'b1;
    e.fd  = '0;
    e.acc = 0;
    case (k)
      0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    for (int k = 0; k < 3; k++) begin
      if (done[k] === 1'b1) begin
        pop_exp(k, e, ok);
        if (!ok) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done[%0d]: got done_o=1 required no outstanding operation", k);
        end else begin
          check($sformatf("full_diff[%0d]", k), 32'(fd[k]), 32'(e.fd));
          check($sformatf("D_o[%0d]", k), 32'(d[k]), 32'(e.fd[W-1:0]));
          check($sformatf("Bout_o[%0d]", k), 32'(bout[k]), 32'(e.fd[W]));
          check($sformatf("latency[%0d]", k), 32'(cyc - e.acc), 32'(nc(k)));
          check($sformatf("busy_at_done[%0d]", k), 32'(busy[k]), 32'd0);
        end
      end
    end
  end

  task automatic issue(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bi);
    a[k]     = av;
    b[k]     = bv;
    bin[k]   = bi;
    start[k] = 1'b1;
    push_exp(k, av, bv, bi);
  endtask

  task automatic wait_done(input int k, input int limit);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (done[k] !== 1'b1 && i < limit);
    if (done[k] !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout[%0d]: got no done_o within %0d cycles required done_o", k, limit);
    end
  endtask

  task automatic run_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input logic [W-1:0] exp_d, input logic exp_bout);
    @(negedge clk);
    issue(k, av, bv, bi);
    @(posedge clk);
    #1 start[k] = 1'b0;
    wait_done(k, nc(k) + 8);
    check("plan_D_o", 32'(d[k]), 32'(exp_d));
    check("plan_Bout_o", 32'(bout[k]), 32'(exp_bout));
  endtask

  // Back-to-back random ops; operand bus is scrambled while busy to catch re-sampling.
  task automatic rand_run(input int k, input int nops);
    logic [W-1:0] av, bv;
    logic         bi;
    @(negedge clk);
    for (int n = 0; n < nops; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      bi = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bv = av;
      issue(k, av, bv, bi);
      @(posedge clk);
      #1;
      a[k]   = W'($urandom);
      b[k]   = W'($urandom);
      bin[k] = 1'($urandom);
      wait_done(k, nc(k) + 4);
    end
    start[k] = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got simulation still running required completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : stim
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; a[k] = '0; b[k] = '0; bin[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_done", 32'(done[k]), 32'd0);
      check("reset_D", 32'(d[k]), 32'd0);
      check("reset_full_diff", 32'(fd[k]), 32'd0);
    end

    run_op(0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
    run_op(0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op(0, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0);
    run_op(1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    run_op(2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);

    // Handshake: start mid-BUSY is ignored, start in the done cycle is taken.
    @(negedge clk);
    issue(0, 16'h0010, 16'h0001, 1'b0);
    @(posedge clk);
    #1 start[0] = 1'b0;
    @(posedge clk);
    #1 a[0] = 16'hAAAA; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0; a[0] = '0;
    wait_done(0, 12);
    check("hs_first_D", 32'(d[0]), 32'h000F);
    issue(0, 16'd5, 16'd7, 1'b0);
    @(posedge clk);
    #1 start[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hs_busy", 32'(busy[0]), 32'd1);
      check("hs_D_hold", 32'(d[0]), 32'h000F);
    end
    wait_done(0, 6);
    check("hs_second_D", 32'(d[0]), 32'hFFFE);
    check("hs_second_Bout", 32'(bout[0]), 32'd1);

    // Reset during BUSY cycle 2 discards the operation.
    @(negedge clk);
    issue(0, 16'h1111, 16'h0001, 1'b0);
    @(posedge clk);
    #1 start[0] = 1'b0;
    @(posedge clk);
    #1 rst[0] = 1'b1;
    q0.delete();
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_D", 32'(d[0]), 32'd0);
    check("rst_Bout", 32'(bout[0]), 32'd0);
    check("rst_full_diff", 32'(fd[0]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(done[0]), 32'd0);
    end
    run_op(0, 16'd3, 16'd1, 1'b0, 16'h0002, 1'b0);

    rand_run(0, 10000);
    rand_run(1, 1000);
    rand_run(2, 600);

    repeat (5) @(negedge clk);
    check("sb_empty_c4", 32'(q0.size()), 32'd0);
    check("sb_empty_c16", 32'(q1.size()), 32'd0);
    check("sb_empty_c1", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
